// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state, opcode and select-line encodings for the MIPS main control
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDI_EX = 4'd10,
    S_ADDI_WB = 4'd11
  } state_e;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_4      = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;
endpackage

// File: rtl/mips_ctrl_decode.sv
// mips_ctrl_decode: pure state-to-control-line decoder for the MIPS main control
// Ports: state (current FSM state) -> ctrl (all datapath select/enable lines).
// Macro MIPS_CTRL_ADDI_EN adds the ADDI_EX/ADDI_WB decodes; otherwise they decode to all-zero.
import mips_ctrl_pkg::*;
module mips_ctrl_decode (
  input  state_e state,
  output ctrl_t  ctrl
);
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_src_b = SRCB_4;
      end
      S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH;
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_JUMP;
      end
`ifdef MIPS_CTRL_ADDI_EN
      S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_ADDI_WB: ctrl.reg_write = 1'b1;
`endif
      default: ctrl = '0;
    endcase
  end
endmodule

// File: rtl/mips_main_control.sv
// mips_main_control: multi-cycle MIPS32 main control Moore FSM
// Ports: Clk, Reset (sync, active-high), Opcode (IR[31:26]) in; datapath control lines,
// IllegalOp (one-cycle pulse in the FETCH after an unsupported opcode) and State (debug) out.
// Macro MIPS_CTRL_ADDI_EN enables ADDI decoding; without it opcode 001000 is illegal.
import mips_ctrl_pkg::*;
module mips_main_control #(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic [OPW-1:0] Opcode,
  output logic           PCWrite,
  output logic           PCWriteCond,
  output logic           IorD,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           IRWrite,
  output logic           MemtoReg,
  output logic           RegDst,
  output logic           RegWrite,
  output logic           ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     ALUOp,
  output logic [1:0]     PCSource,
  output logic           IllegalOp,
  output logic [STW-1:0] State
);
  state_e state_q, state_d;
  logic ill_q, ill_d;
  logic [5:0] op;
  ctrl_t ctrl, ctrl_g;
  assign op = 6'(Opcode);
  always_comb begin
    state_d = S_FETCH;
    ill_d = 1'b0;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (op == OP_LW || op == OP_SW) state_d = S_MEMADR;
        else if (op == OP_R) state_d = S_EXEC;
        else if (op == OP_BEQ) state_d = S_BRANCH;
        else if (op == OP_J) state_d = S_JUMP;
`ifdef MIPS_CTRL_ADDI_EN
        else if (op == OP_ADDI) state_d = S_ADDI_EX;
`endif
        else ill_d = 1'b1;
      end
      S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: state_d = S_MEMWB;
      S_EXEC: state_d = S_RWB;
`ifdef MIPS_CTRL_ADDI_EN
      S_ADDI_EX: state_d = S_ADDI_WB;
`endif
      default: state_d = S_FETCH;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_FETCH;
      ill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ill_q <= ill_d;
    end
  end
  mips_ctrl_decode u_decode (
    .state (state_q),
    .ctrl  (ctrl)
  );
  // Reset masks every output immediately so an aborted instruction cannot write anything.
  assign ctrl_g      = Reset ? '0 : ctrl;
  assign PCWrite     = ctrl_g.pc_write;
  assign PCWriteCond = ctrl_g.pc_write_cond;
  assign IorD        = ctrl_g.i_or_d;
  assign MemRead     = ctrl_g.mem_read;
  assign MemWrite    = ctrl_g.mem_write;
  assign IRWrite     = ctrl_g.ir_write;
  assign MemtoReg    = ctrl_g.mem_to_reg;
  assign RegDst      = ctrl_g.reg_dst;
  assign RegWrite    = ctrl_g.reg_write;
  assign ALUSrcA     = ctrl_g.alu_src_a;
  assign ALUSrcB     = ctrl_g.alu_src_b;
  assign ALUOp       = ctrl_g.alu_op;
  assign PCSource    = ctrl_g.pc_source;
  assign IllegalOp   = ~Reset & ill_q;
  assign State       = Reset ? '0 : STW'(state_q);
endmodule

// File: tb/tb_mips_main_control.sv
// tb_mips_main_control: directed + random check of mips_main_control against a route-based model
module tb_mips_main_control;
  logic       Clk = 1'b0;
  logic       Reset;
  logic [5:0] Opcode;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, IllegalOp;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] State;
  int total = 0;
  int bad = 0;
  int m_state;
  bit m_ill;
  int route[$];
  bit prev_rw;
  logic [5:0] ops [0:6];
  mips_main_control dut (
    .Clk(Clk), .Reset(Reset), .Opcode(Opcode),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .IllegalOp(IllegalOp), .State(State)
  );
  always #5 Clk = ~Clk;
  // Control lines per state as listed: {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,
  // MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource}
  function automatic logic [15:0] exp_ctrl(int s);
    case (s)
      0:  return 16'b1_0_0_1_0_1_0_0_0_0_01_00_00;
      1:  return 16'b0_0_0_0_0_0_0_0_0_0_11_00_00;
      2:  return 16'b0_0_0_0_0_0_0_0_0_1_10_00_00;
      3:  return 16'b0_0_1_1_0_0_0_0_0_0_00_00_00;
      4:  return 16'b0_0_0_0_0_0_1_0_1_0_00_00_00;
      5:  return 16'b0_0_1_0_1_0_0_0_0_0_00_00_00;
      6:  return 16'b0_0_0_0_0_0_0_0_0_1_00_10_00;
      7:  return 16'b0_0_0_0_0_0_0_1_1_0_00_00_00;
      8:  return 16'b0_1_0_0_0_0_0_0_0_1_00_01_01;
      9:  return 16'b1_0_0_0_0_0_0_0_0_0_00_00_10;
      10: return 16'b0_0_0_0_0_0_0_0_0_1_10_00_00;
      11: return 16'b0_0_0_0_0_0_0_0_1_0_00_00_00;
      default: return 16'b0;
    endcase
  endfunction
  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h (model state %0d, time %0t)", tag, got, exp, m_state, $time);
    end
  endtask
  task automatic check_now();
    logic [15:0] got;
    got = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};
    chk("state", 16'(State), Reset ? 16'd0 : 16'(m_state));
    chk("ctrl", got, Reset ? 16'd0 : exp_ctrl(m_state));
    chk("illegal", 16'(IllegalOp), 16'(m_ill && !Reset));
    chk("rw_consecutive", 16'(prev_rw && RegWrite), 16'd0);
    chk("rd_wr_overlap", 16'(MemRead && MemWrite), 16'd0);
    prev_rw = RegWrite;
  endtask
  // Each instruction is a fixed route of states after DECODE; an empty route means illegal.
  task automatic model_edge(bit r, logic [5:0] op);
    if (r) begin
      m_state = 0;
      m_ill = 0;
      route.delete();
    end else begin
      m_ill = 0;
      if (m_state == 0) m_state = 1;
      else begin
        if (m_state == 1) begin
          route.delete();
          case (op)
            6'b100011: route = '{2, 3, 4};
            6'b101011: route = '{2, 5};
            6'b000000: route = '{6, 7};
            6'b000100: route = '{8};
            6'b000010: route = '{9};
`ifdef MIPS_CTRL_ADDI_EN
            6'b001000: route = '{10, 11};
`endif
            default: m_ill = 1;
          endcase
        end
        m_state = (route.size() > 0) ? route.pop_front() : 0;
      end
    end
  endtask
  task automatic step(bit r, logic [5:0] op);
    Reset = r;
    Opcode = op;
    #2;
    check_now();
    @(posedge Clk);
    model_edge(r, op);
    #1;
  endtask
  task automatic instr(logic [5:0] op);
    int guard = 0;
    step(1'b0, op);
    while (m_state != 0 && guard < 10) begin
      step(1'b0, op);
      guard++;
    end
    total++;
    assert (guard < 10) else begin
      bad++;
      $error("FAIL instr_timeout got=%0d exp=<10 op=%0b", guard, op);
    end
  endtask
  initial begin
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000, 6'b111111};
    prev_rw = 1'b0;
    Reset = 1'b1;
    Opcode = 6'b100011;
    @(posedge Clk);
    model_edge(1'b1, Opcode);
    #1;
    step(1'b1, 6'b100011);
    step(1'b1, 6'b100011);
    step(1'b1, 6'b100011);
    instr(6'b100011);
    instr(6'b101011);
    instr(6'b000000);
    instr(6'b000100);
    instr(6'b111111);
    instr(6'b100011);
    instr(6'b001000);
    instr(6'b000010);
    step(1'b0, 6'b100011);
    step(1'b0, 6'b100011);
    step(1'b0, 6'b100011);
    step(1'b1, 6'b100011);
    step(1'b1, 6'b100011);
    instr(6'b100011);
    instr(6'b001000);
    for (int n = 0; n < 600; n++) begin
      int k;
      logic [5:0] op;
      k = $urandom_range(0, 7);
      op = (k == 7) ? 6'($urandom) : ops[k];
      if ($urandom_range(0, 39) == 0) begin
        step(1'b1, op);
        step(1'b0, op);
      end
      if (m_state == 0) instr(op);
      else step(1'b0, op);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
